ui_input_controller: RTL and testbench
======================================

Name: ui_input_controller

Overview:
- Converts six raw front-panel pushbuttons into the UI selection state that drives the on-screen menu highlight overlay and cursor drawing.
- Synchronises, debounces and edge-detects each button, with auto-repeat on the direction buttons.
- Runs a two-mode UI state machine (channel mode / cursor mode) that updates the selected channel, the selected cursor pair and four cursor coordinates.
- Outputs change only on a frame boundary, so the overlay never tears mid-frame.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button level change (10 ms at 25 MHz)
REPEAT_DELAY, 12500000, hold cycles before the first auto-repeat (0.5 s)
REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeats (100 ms)
X_MAX, 639, upper clamp for X cursors
Y_MAX, 479, upper clamp for Y cursors

Ports:
clock25MHz  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high
btnMode  in  1  raw async button, toggles uiMode
btnNext  in  1  raw async button, next channel / toggle cursor pair
btnUp  in  1  raw async button, cursor Y decrement
btnDown  in  1  raw async button, cursor Y increment
btnLeft  in  1  raw async button, cursor X decrement
btnRight  in  1  raw async button, cursor X increment
frameStart  in  1  one-cycle pulse at start of vertical blank
uiMode  out  1  0 = channel mode, 1 = cursor mode
selectedChannel  out  2  0..3
selectedCursorPair  out  1  0 = X1/Y1, 1 = X2/Y2
cursorX1  out  10  pixel X, 0..X_MAX
cursorY1  out  10  pixel Y, 0..Y_MAX
cursorX2  out  10  pixel X, 0..X_MAX
cursorY2  out  10  pixel Y, 0..Y_MAX

Behaviour:
- Reset values, applied to both working and output registers: uiMode=0, selectedChannel=0, selectedCursorPair=0, X1=160, Y1=120, X2=480, Y2=360. All debounced states 0, all counters 0.
- Input path, per button:
  - 2-flop synchroniser.
  - The debounce counter increments while the synced level differs from the debounced state. It clears on any agreeing cycle.
  - The debounced state flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle, and the counter clears.
  - A press pulse (1 cycle) fires on a debounced 0->1 transition. Releases produce no event.
- Auto-repeat (Up/Down/Left/Right only):
  - A hold counter runs while the debounced state is 1.
  - An extra press pulse fires at REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
  - The counter clears on release. Mode and Next never repeat.
- Working registers update on the cycle after a press pulse. Event priority within one cycle:
  - Mode press: toggle uiMode. All other events in that cycle are discarded.
  - Else Next press: in channel mode, selectedChannel+1 mod 4 (3->0). In cursor mode, toggle selectedCursorPair.
  - Movement events apply in the same cycle as Next, using the pre-Next pair.
  - Up and Down together: both ignored. Left and Right together: both ignored.
- Movement applies only in cursor mode; it is ignored in channel mode. It targets the selected pair (X1/Y1 or X2/Y2).
- Movement step is 1 pixel, saturating:
  - Decrement at 0 stays 0.
  - Increment at X_MAX / Y_MAX stays at that value.
  - No wrap ever.
- selectedChannel and selectedCursorPair are retained across mode toggles.
- Output registers copy the working registers on the clock edge where frameStart=1.
  - If a working update lands on that same edge, the outputs take the pre-update value; the new value appears at the next frameStart.
  - Outputs never change on any other cycle.
- Latency:
  - Raw edge to debounced change = 2 sync cycles + DEBOUNCE_CYCLES.
  - Then press pulse, then working update 1 cycle later, then output update at the next frameStart.
- Reset asserted mid-debounce or mid-hold aborts everything with no event.
  - A button still held when reset is released is treated as a fresh press after DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, frameStart every 50 cycles):
- Reset, then 2 frameStarts, no buttons -> outputs hold 0/0/0/160/120/480/360 throughout.
- 4 separate Next presses in channel mode, one frameStart after each -> selectedChannel 1,2,3,0. A 3-cycle Next glitch -> no change.
- Mode press, then Next, then hold Right 40 cycles -> uiMode=1, pair=1, X2 = 480 + 1 + 1 (at 20) + 3 repeats (25,30,35) = 485. X1 unchanged. Outputs change only on frameStart edges.
- Cursor mode, pair 0, Y1 forced to 0 via repeated Up, one more Up -> Y1 stays 0. X1 at 639 plus Right -> stays 639.
- Mode and Next pressed same cycle -> only uiMode toggles. Up and Down same cycle -> Y unchanged. Left in channel mode -> no change.
- Press resolving on the same edge as frameStart -> outputs show old value until the following frameStart. Reset asserted during a hold -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/ui_input_controller.sv
// ui_input_controller: front-panel button conditioning and UI selection state.
// Six raw buttons are synchronised, debounced and edge-detected; the four
// direction buttons also auto-repeat while held. A two-mode state machine
// (channel / cursor) updates working registers, which are copied to the
// outputs only on frameStart so the overlay never changes mid-frame.
// There is no handshake on this block: press events are single-cycle
// pulses that are consumed on the clock edge that ends the pulse cycle.
module ui_input_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479
) (
    input  logic       clock25MHz,
    input  logic       reset,
    input  logic       btnMode,
    input  logic       btnNext,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       frameStart,
    output logic       uiMode,
    output logic [1:0] selectedChannel,
    output logic       selectedCursorPair,
    output logic [9:0] cursorX1,
    output logic [9:0] cursorY1,
    output logic [9:0] cursorX2,
    output logic [9:0] cursorY2
);

    // Button bit positions: 0 mode, 1 next, 2 up, 3 down, 4 left, 5 right.
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(REPEAT_DELAY + 1);

    // UI state machine encoding; uiMode is the registered image of this state.
    localparam logic MODE_CHANNEL = 1'b0;
    localparam logic MODE_CURSOR  = 1'b1;

    localparam logic [9:0] X1_RST = 10'd160;
    localparam logic [9:0] Y1_RST = 10'd120;
    localparam logic [9:0] X2_RST = 10'd480;
    localparam logic [9:0] Y2_RST = 10'd360;

    logic [5:0]    raw;
    logic [5:0]    sync1;
    logic [5:0]    sync2;
    logic [5:0]    deb;
    logic [5:0]    deb_d;
    logic [DW-1:0] dcnt [6];
    logic [HW-1:0] hold [4];
    logic [5:0]    press;
    logic [3:0]    rep;
    logic [5:0]    ev;

    logic       work_mode;
    logic [1:0] work_ch;
    logic       work_pair;
    logic [9:0] work_x1;
    logic [9:0] work_y1;
    logic [9:0] work_x2;
    logic [9:0] work_y2;

    logic       x_dec;
    logic       x_inc;
    logic       y_dec;
    logic       y_inc;
    logic [9:0] cur_x;
    logic [9:0] cur_y;
    logic [9:0] nxt_x;
    logic [9:0] nxt_y;

    assign raw = {btnRight, btnLeft, btnDown, btnUp, btnNext, btnMode};

    // Two-flop synchroniser for every raw button.
    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: the accepted level flips after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 6; i++) dcnt[i] <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]  <= ~deb[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Hold counters for the direction buttons. On reaching REPEAT_DELAY the
    // counter is pulled back so it reaches REPEAT_DELAY again every
    // REPEAT_PERIOD cycles, reusing one comparator for both repeat phases.
    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!deb[i+2]) begin
                    hold[i] <= '0;
                end else if (hold[i] == HW'(REPEAT_DELAY)) begin
                    hold[i] <= HW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
                end else begin
                    hold[i] <= hold[i] + 1'b1;
                end
            end
        end
    end

    // Press and repeat pulses merged into one event vector.
    always_comb begin
        press = deb & ~deb_d;
        for (int i = 0; i < 4; i++) begin
            rep[i] = deb[i+2] && (hold[i] == HW'(REPEAT_DELAY));
        end
        ev = press | {rep, 2'b00};
    end

    // Saturating one-pixel step on the currently selected cursor pair.
    // Opposing directions in the same cycle cancel.
    always_comb begin
        y_dec = ev[2] & ~ev[3];
        y_inc = ev[3] & ~ev[2];
        x_dec = ev[4] & ~ev[5];
        x_inc = ev[5] & ~ev[4];
        cur_x = work_pair ? work_x2 : work_x1;
        cur_y = work_pair ? work_y2 : work_y1;
        nxt_x = cur_x;
        nxt_y = cur_y;
        if (x_dec && cur_x != 10'd0) begin
            nxt_x = cur_x - 10'd1;
        end else if (x_inc && cur_x < 10'(X_MAX)) begin
            nxt_x = cur_x + 10'd1;
        end
        if (y_dec && cur_y != 10'd0) begin
            nxt_y = cur_y - 10'd1;
        end else if (y_inc && cur_y < 10'(Y_MAX)) begin
            nxt_y = cur_y + 10'd1;
        end
    end

    // UI state machine and working registers. Mode wins and swallows every
    // other event of its cycle; movement uses the pair selected before Next.
    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            work_mode <= MODE_CHANNEL;
            work_ch   <= 2'd0;
            work_pair <= 1'b0;
            work_x1   <= X1_RST;
            work_y1   <= Y1_RST;
            work_x2   <= X2_RST;
            work_y2   <= Y2_RST;
        end else if (ev[0]) begin
            work_mode <= (work_mode == MODE_CHANNEL) ? MODE_CURSOR : MODE_CHANNEL;
        end else begin
            if (work_mode == MODE_CURSOR) begin
                if (!work_pair) begin
                    work_x1 <= nxt_x;
                    work_y1 <= nxt_y;
                end else begin
                    work_x2 <= nxt_x;
                    work_y2 <= nxt_y;
                end
            end
            if (ev[1]) begin
                if (work_mode == MODE_CHANNEL) begin
                    work_ch <= work_ch + 2'd1;
                end else begin
                    work_pair <= ~work_pair;
                end
            end
        end
    end

    // Frame-synchronous output copy; an update landing on the same edge
    // shows up at the following frameStart.
    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            uiMode             <= MODE_CHANNEL;
            selectedChannel    <= 2'd0;
            selectedCursorPair <= 1'b0;
            cursorX1           <= X1_RST;
            cursorY1           <= Y1_RST;
            cursorX2           <= X2_RST;
            cursorY2           <= Y2_RST;
        end else if (frameStart) begin
            uiMode             <= work_mode;
            selectedChannel    <= work_ch;
            selectedCursorPair <= work_pair;
            cursorX1           <= work_x1;
            cursorY1           <= work_y1;
            cursorX2           <= work_x2;
            cursorY2           <= work_y2;
        end
    end

endmodule

// File: tb/tb_ui_input_controller.sv
// tb_ui_input_controller: randomized and directed button sequences checked
// against a transaction-level model. Each operation holds a set of buttons
// for H cycles starting d cycles after a frameStart; the model turns that
// hold into a list of press/repeat events with their update cycles and
// predicts the outputs at the next two frame boundaries.
module tb_ui_input_controller;

    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int FP   = 50;
    localparam int XM   = 639;
    localparam int YM   = 479;
    localparam logic [43:0] RST_V = {1'b0, 2'd0, 1'b0, 10'd160, 10'd120, 10'd480, 10'd360};

    // ---------------- clock / reset ----------------
    logic clock25MHz = 1'b0;
    always #20 clock25MHz = ~clock25MHz;

    logic       reset = 1'b1;
    logic       btnMode = 1'b0, btnNext = 1'b0, btnUp = 1'b0;
    logic       btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
    logic       frameStart = 1'b0;
    logic       uiMode;
    logic [1:0] selectedChannel;
    logic       selectedCursorPair;
    logic [9:0] cursorX1, cursorY1, cursorX2, cursorY2;
    logic [43:0] obs;

    ui_input_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .X_MAX(XM),
        .Y_MAX(YM)
    ) dut (
        .clock25MHz(clock25MHz),
        .reset(reset),
        .btnMode(btnMode),
        .btnNext(btnNext),
        .btnUp(btnUp),
        .btnDown(btnDown),
        .btnLeft(btnLeft),
        .btnRight(btnRight),
        .frameStart(frameStart),
        .uiMode(uiMode),
        .selectedChannel(selectedChannel),
        .selectedCursorPair(selectedCursorPair),
        .cursorX1(cursorX1),
        .cursorY1(cursorY1),
        .cursorX2(cursorX2),
        .cursorY2(cursorY2)
    );

    assign obs = {uiMode, selectedChannel, selectedCursorPair, cursorX1, cursorY1, cursorX2, cursorY2};

    // Free-running frameStart pulse, one cycle every FP cycles.
    int cyc = 0;
    initial begin
        forever begin
            @(negedge clock25MHz);
            cyc++;
            frameStart = (cyc % FP == 0);
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [43:0] exp_q[$];

    task automatic check_vec(input string tag, input logic [43:0] got, input logic [43:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got mode=%0d ch=%0d pair=%0d x1=%0d y1=%0d x2=%0d y2=%0d, expected mode=%0d ch=%0d pair=%0d x1=%0d y1=%0d x2=%0d y2=%0d",
                     tag, got[43], got[42:41], got[40], got[39:30], got[29:20], got[19:10], got[9:0],
                     exp[43], exp[42:41], exp[40], exp[39:30], exp[29:20], exp[19:10], exp[9:0]);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_ch, m_pair;
    int m_x[2];
    int m_y[2];

    function automatic void model_reset();
        m_mode = 0; m_ch = 0; m_pair = 0;
        m_x[0] = 160; m_y[0] = 120; m_x[1] = 480; m_y[1] = 360;
    endfunction

    function automatic logic [43:0] model_vec();
        return {1'(m_mode), 2'(m_ch), 1'(m_pair), 10'(m_x[0]), 10'(m_y[0]), 10'(m_x[1]), 10'(m_y[1])};
    endfunction

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // One event with button set s (bit 0 mode .. bit 5 right).
    function automatic void apply_event(input logic [5:0] s);
        int dx, dy;
        if (s[0]) begin
            m_mode = 1 - m_mode;
            return;
        end
        if (m_mode == 1) begin
            dy = (s[3] ? 1 : 0) - (s[2] ? 1 : 0);
            dx = (s[5] ? 1 : 0) - (s[4] ? 1 : 0);
            m_x[m_pair] = clamp(m_x[m_pair] + dx, XM);
            m_y[m_pair] = clamp(m_y[m_pair] + dy, YM);
        end
        if (s[1]) begin
            if (m_mode == 0) m_ch = (m_ch + 1) % 4;
            else m_pair = 1 - m_pair;
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic set_btns(input logic [5:0] m);
        btnMode = m[0]; btnNext = m[1]; btnUp = m[2];
        btnDown = m[3]; btnLeft = m[4]; btnRight = m[5];
    endtask

    // Returns #1 after the next frameStart edge.
    task automatic wait_frame();
        int n = 0;
        do begin
            @(posedge clock25MHz);
            n++;
        end while (!frameStart && n < 4 * FP);
        #1;
        if (n >= 4 * FP) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame_timeout: got no frameStart within %0d cycles, required one", n);
        end
    endtask

    // Hold button set m for h cycles starting d cycles after a frameStart,
    // with d + h <= 93 so every event lands before the second frame edge.
    task automatic op(input string tag, input logic [5:0] m, input int h, input int d);
        int offs[$];
        logic [5:0] sets[$];
        wait_frame();
        exp_q.push_back(model_vec());
        if (h >= DEB) begin
            offs.push_back(d + 7);
            sets.push_back(m);
            if (m[5:2] != 4'b0) begin
                for (int t = RD; t <= h - 1; t += RP) begin
                    offs.push_back(d + 7 + t);
                    sets.push_back({m[5:2], 2'b00});
                end
            end
        end
        for (int k = 0; k < offs.size(); k++) if (offs[k] < FP) apply_event(sets[k]);
        exp_q.push_back(model_vec());
        for (int k = 0; k < offs.size(); k++) if (offs[k] >= FP) apply_event(sets[k]);
        exp_q.push_back(model_vec());
        for (int i = 0; i < 2 * FP; i++) begin
            if (i == d) set_btns(m);
            if (i == d + h) set_btns(6'b0);
            if (i == FP - 1) check_vec({tag, "_pre"}, obs, exp_q.pop_front());
            if (i == FP) check_vec({tag, "_frame1"}, obs, exp_q.pop_front());
            @(posedge clock25MHz);
            #1;
        end
        check_vec({tag, "_frame2"}, obs, exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        logic [5:0] m;
        int h, d;

        model_reset();
        set_btns(6'b0);
        repeat (3) @(posedge clock25MHz);
        #1;
        check_vec("reset_state", obs, RST_V);
        reset = 1'b0;
        wait_frame();
        check_vec("idle_frame1", obs, RST_V);
        wait_frame();
        check_vec("idle_frame2", obs, RST_V);

        // Channel mode: four Next presses cycle 1,2,3,0; short glitch ignored.
        for (int i = 0; i < 4; i++) op("next_ch", 6'b000010, 10, 5);
        op("next_glitch", 6'b000010, 3, 5);

        // Enter cursor mode, select pair 1, hold Right 40 cycles.
        op("mode_on", 6'b000001, 10, 5);
        op("next_pair", 6'b000010, 10, 5);
        op("right_hold40", 6'b100000, 40, 0);
        check_vec("x2_is_485", {34'b0, cursorX2}, 44'd485);

        // Back to pair 0, drive Y1 to 0 then one more Up.
        op("next_pair0", 6'b000010, 10, 5);
        guard = 0;
        while (m_y[0] > 0 && guard < 20) begin
            op("up_to_zero", 6'b000100, 88, 0);
            guard++;
        end
        op("up_at_zero", 6'b000100, 10, 3);
        check_vec("y1_is_0", {34'b0, cursorY1}, 44'd0);

        // Drive X1 to X_MAX then one more Right.
        guard = 0;
        while (m_x[0] < XM && guard < 40) begin
            op("right_to_max", 6'b100000, 88, 0);
            guard++;
        end
        op("right_at_max", 6'b100000, 10, 2);
        check_vec("x1_is_639", {34'b0, cursorX1}, 44'd639);

        // Mode+Next together, Left in channel mode, opposing pairs.
        op("mode_next", 6'b000011, 10, 4);
        op("left_chmode", 6'b010000, 10, 4);
        op("mode_on2", 6'b000001, 10, 4);
        op("up_down", 6'b001100, 10, 4);
        op("left_right", 6'b110000, 30, 2);

        // Working update lands exactly on a frameStart edge.
        op("next_on_frame", 6'b000010, 10, 43);
        op("down_on_frame", 6'b001000, 10, 43);

        // Randomized operations.
        for (int r = 0; r < 30; r++) begin
            m = 6'(1 << $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) m = m | 6'(1 << $urandom_range(0, 5));
            h = $urandom_range(1, 60);
            d = $urandom_range(0, 30);
            op("rand", m, h, d);
        end

        // Reset in the middle of a Right hold.
        wait_frame();
        set_btns(6'b100000);
        repeat (20) @(posedge clock25MHz);
        #1;
        reset = 1'b1;
        @(posedge clock25MHz);
        #1;
        check_vec("reset_mid_hold", obs, RST_V);
        set_btns(6'b0);
        repeat (2) @(posedge clock25MHz);
        #1;
        reset = 1'b0;
        model_reset();
        wait_frame();
        check_vec("post_reset_frame1", obs, model_vec());
        wait_frame();
        check_vec("post_reset_frame2", obs, model_vec());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
